// File: rtl/apb_bridge_pkg.sv
// APB bridge shared types and helpers.
// Imported by the bridge top and its timeout counter.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    DERR
  } bridge_state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned IDX_OUT_W = 4;

  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(
    input logic [ERR_CNT_W-1:0] v
  );
    logic [ERR_CNT_W-1:0] r;
    r = v;
    if (v != '1) r = v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog for the APB bridge.
// expired is registered, so it trails the limit by one cycle.
module apb_timeout_cnt
  import apb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK50M,
  input  logic RSTN,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CNT_W =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIM =
    CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit ENA = (TIMEOUT != 0);

  logic [CNT_W-1:0] cnt;
  logic             at_lim;

  assign at_lim = (cnt == LIM);

  // Counter parks at the limit instead of wrapping.
  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (en) begin
      if (!at_lim) cnt <= cnt + 1'b1;
      expired <= ENA && at_lim;
    end
  end

endmodule

// File: rtl/apb_slave_bridge_n.sv
// APB3 bridge: one master port fanned out to NUM_SLV slaves.
// Adds decode error, watchdog timeout and sticky error status.
module apb_slave_bridge_n
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_SLV = 8,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEL_LSB = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA =
    DATA_W'(ERR_DATA_DEF)
) (
  input  logic                      CLK50M,
  input  logic                      RSTN,
  input  logic                      m_psel,
  input  logic                      m_penable,
  input  logic                      m_pwrite,
  input  logic [ADDR_W-1:0]         m_paddr,
  input  logic [DATA_W-1:0]         m_pwdata,
  output logic [DATA_W-1:0]         m_prdata,
  output logic                      m_pready,
  output logic                      m_pslverr,
  output logic [NUM_SLV-1:0]        s_psel,
  output logic                      s_penable,
  output logic                      s_pwrite,
  output logic [ADDR_W-1:0]         s_paddr,
  output logic [DATA_W-1:0]         s_pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] s_prdata,
  input  logic [NUM_SLV-1:0]        s_pready,
  input  logic [NUM_SLV-1:0]        s_pslverr,
  output logic                      err_irq,
  output logic [ERR_CNT_W-1:0]      err_cnt,
  output logic [IDX_OUT_W-1:0]      err_last_idx
);

  localparam int unsigned SEL_W = sel_w(NUM_SLV);

  bridge_state_t state;

  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   in_idx;
  logic               in_hit;
  logic               setup_req;
  logic [NUM_SLV-1:0] in_onehot;

  logic [DATA_W-1:0]  mux_rdata;
  logic               mux_rdy;
  logic               mux_err;

  logic               to_en;
  logic               to_clr;
  logic               to_expired;

  assign in_idx    = m_paddr[SEL_LSB +: SEL_W];
  assign in_hit    = (32'(in_idx) < NUM_SLV);
  assign setup_req = m_psel && !m_penable;
  assign in_onehot = NUM_SLV'(1) << in_idx;

  // Only the latched slave is looked at during ACCESS.
  always_comb begin
    mux_rdata = '0;
    mux_rdy   = 1'b0;
    mux_err   = 1'b0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (idx == SEL_W'(i)) begin
        mux_rdata = s_prdata[i*DATA_W +: DATA_W];
        mux_rdy   = s_pready[i];
        mux_err   = s_pslverr[i];
      end
    end
  end

  assign to_en  = (state == ACCESS);
  assign to_clr = !to_en;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK50M  (CLK50M),
    .RSTN    (RSTN),
    .en      (to_en),
    .clr     (to_clr),
    .expired (to_expired)
  );

  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      state        <= IDLE;
      idx          <= '0;
      s_psel       <= '0;
      s_penable    <= 1'b0;
      s_pwrite     <= 1'b0;
      s_paddr      <= '0;
      s_pwdata     <= '0;
      m_prdata     <= '0;
      m_pready     <= 1'b0;
      m_pslverr    <= 1'b0;
      err_irq      <= 1'b0;
      err_cnt      <= '0;
      err_last_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          m_prdata  <= '0;
          m_pready  <= 1'b0;
          m_pslverr <= 1'b0;
          err_irq   <= 1'b0;
          if (setup_req) begin
            idx      <= in_idx;
            s_paddr  <= m_paddr;
            s_pwrite <= m_pwrite;
            s_pwdata <= m_pwdata;
            if (in_hit) begin
              s_psel <= in_onehot;
              state  <= SETUP;
            end else begin
              m_pready     <= 1'b1;
              m_pslverr    <= 1'b1;
              m_prdata     <= m_pwrite ? '0 : ERR_DATA;
              err_irq      <= 1'b1;
              err_cnt      <= sat_inc(err_cnt);
              err_last_idx <= IDX_OUT_W'(in_idx);
              state        <= DERR;
            end
          end
        end
        SETUP: begin
          s_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // Slave ready wins over a same-cycle timeout.
          if (mux_rdy) begin
            s_psel    <= '0;
            s_penable <= 1'b0;
            m_pready  <= 1'b1;
            m_pslverr <= mux_err;
            m_prdata  <= s_pwrite ? '0 : mux_rdata;
            if (mux_err) begin
              err_cnt      <= sat_inc(err_cnt);
              err_last_idx <= IDX_OUT_W'(idx);
            end
            state <= RESP;
          end else if (to_expired) begin
            s_psel       <= '0;
            s_penable    <= 1'b0;
            m_pready     <= 1'b1;
            m_pslverr    <= 1'b1;
            m_prdata     <= ERR_DATA;
            err_irq      <= 1'b1;
            err_cnt      <= sat_inc(err_cnt);
            err_last_idx <= IDX_OUT_W'(idx);
            state        <= RESP;
          end
        end
        RESP, DERR: begin
          m_prdata  <= '0;
          m_pready  <= 1'b0;
          m_pslverr <= 1'b0;
          err_irq   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
